egk_stream_binarizer: RTL and testbench
=======================================

Name: egk_stream_binarizer

Overview:
- Parametrised successor to the single-symbol k-th order Exp-Golomb (EGk) coder in the HEVC binarization path.
- Accepts a stream of symbols, each with its own Rice/EG order K, over a valid/ready handshake.
- Emits the HEVC EGk bin string one bin per cycle on a backpressured output, with last-bin flag and codeword length.
- Feeds the CABAC bypass-bin engine.

Parameters:
SYMBOL_BITS, 16, width of symbol input.
K_BITS, 4, width of K input; any value 0..2^K_BITS-1 is legal.
LEN_BITS, 8, width of codeword length output; must hold 2*(SYMBOL_BITS+1)+2^K_BITS.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  symbol offered.
in_ready  out  1  block can accept a symbol.
in_symbol  in  SYMBOL_BITS  symbol value (unsigned, or two's complement under SIGNED_MAP_EN).
in_k  in  K_BITS  EG order for this symbol.
bin_valid  out  1  bin_out is valid.
bin_ready  in  1  downstream accepts bin.
bin_out  out  1  current bin.
bin_last  out  1  current bin is the final bin of the codeword.
code_len  out  LEN_BITS  total bins of the codeword; valid when bin_valid && bin_last.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). All state updates on the rising clk edge.
- Reset values: state IDLE, in_ready=1, bin_valid=0, bin_out=0, bin_last=0, code_len=0.
- Internal registers:
  - rem: residual, SYMBOL_BITS+1 bits.
  - kc: current order, 6 bits minimum (must reach 2^K_BITS-1+SYMBOL_BITS+1).
  - len: bin count, LEN_BITS.
- FSM states: IDLE, PREFIX, SUFFIX.
- IDLE:
  - in_ready=1, bin_valid=0.
  - On in_valid&&in_ready: rem=mapped symbol, kc=in_k, len=0; go to PREFIX.
  - First bin is valid the cycle after acceptance.
- PREFIX:
  - bin_valid=1; bin_out=1 when rem >= 2^kc, else 0.
  - Comparison is width-safe: if kc >= SYMBOL_BITS+1, treat 2^kc as exceeding rem (bin_out=0).
  - On handshake with bin_out=1: rem -= 2^kc, kc += 1, len += 1; stay in PREFIX.
  - On handshake with bin_out=0: len += 1; go to SUFFIX if kc>0; if kc==0 this bin is last, go to IDLE.
- SUFFIX:
  - bin_valid=1; bin_out=rem[kc-1].
  - On handshake: kc -= 1, len += 1; bin_last=1 when kc==1; after the last bin, go to IDLE.
- bin_last, code_len and bin_out are combinational from registered state and stable while bin_valid && !bin_ready.
- code_len = len+1 on the last bin, i.e. full codeword length.
- in_ready=0 in PREFIX/SUFFIX. No overlap: next symbol is accepted no earlier than the cycle after the last-bin handshake.
- Throughput: codeword length + 1 cycles per symbol with bin_ready held at 1.
- Length formula: prefix ones q, then 1 terminating zero, then kc_final suffix bins; total q+1+in_k+q.
- rst asserted mid-codeword: codeword is abandoned, all outputs return to reset values the next cycle, no partial bins are emitted afterwards.
- in_valid while busy is ignored (not latched).

Optional Feature:
- Macro: HEVC_EGK_SIGNED_MAP_EN.
- Defined: in_symbol is two's complement, mapped at acceptance: v>0 gives 2v-1; v<=0 gives -2v. Result is SYMBOL_BITS+1 wide; -2^(SYMBOL_BITS-1) maps to 2^SYMBOL_BITS.
- Undefined: in_symbol is zero-extended unsigned; mapping logic is absent.

Decomposition:
- Package egk_pkg: state enum (IDLE/PREFIX/SUFFIX), residual-width and kc-width localparams, function computing max codeword length for LEN_BITS checks.
- Sub-module egk_sign_map: combinational signed-to-unsigned mapper, instantiated only under HEVC_EGK_SIGNED_MAP_EN.

Test Plan:
- K=1, sym=0, bin_ready=1 -> bins 0,0; last on bin 2; code_len=2.
- K=1, sym=3 -> bins 1,0,0,1; code_len=4. K=0, sym=5 -> bins 1,1,0,1,0; code_len=5.
- K=0, sym=0xFFFF, unsigned build -> sixteen 1s, one 0, sixteen 0s; code_len=33 (width check).
- Signed build, K=1, sym=-3 (0xFFFD) maps to 6 -> bins 1,1,0,0,0,0; code_len=6. Sym=+3 maps to 5 -> 1,0,0,1,1? no: 5>=2 gives 1, rem 3, kc 2; 3<4 gives 0; suffix 11 -> bins 1,0,1,1; code_len=4.
- Backpressure: bin_ready toggling 1,0,0,1 on K=1 sym=3 -> bin_out/bin_last stable while stalled; same bin sequence; in_ready low until cycle after last handshake.
- rst pulsed for 1 cycle during SUFFIX -> next cycle bin_valid=0, in_ready=1; next symbol (K=0, sym=0) gives single bin 0, code_len=1.

Source files
------------

// File: rtl/egk_pkg.sv
// Shared types and width helpers for the EGk stream binarizer.
package egk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        SUFFIX = 2'd2
    } egk_state_e;

    localparam int DEF_SYMBOL_BITS = 16;
    localparam int DEF_K_BITS      = 4;

    // Residual holds a mapped symbol, which can be one bit wider than the input.
    function automatic int rem_width(int sym_bits);
        return sym_bits + 1;
    endfunction

    // kc must reach the largest order plus one step per prefix bin.
    function automatic int kc_width(int sym_bits, int k_bits);
        int w;
        w = $clog2((2 ** k_bits) - 1 + sym_bits + 1 + 1);
        return (w < 6) ? 6 : w;
    endfunction

    function automatic int max_code_len(int sym_bits, int k_bits);
        return 2 * (sym_bits + 1) + (2 ** k_bits);
    endfunction

    localparam int DEF_REM_W = rem_width(DEF_SYMBOL_BITS);
    localparam int DEF_KC_W  = kc_width(DEF_SYMBOL_BITS, DEF_K_BITS);

endpackage

// File: rtl/egk_stream_binarizer_if.sv
// Symbol-in / bin-out handshake bundle; master drives symbols and bin_ready.
interface egk_stream_binarizer_if #(
    parameter int SYMBOL_BITS = 16,
    parameter int K_BITS      = 4,
    parameter int LEN_BITS    = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [SYMBOL_BITS-1:0] in_symbol;
    logic [K_BITS-1:0]      in_k;
    logic                   bin_valid;
    logic                   bin_ready;
    logic                   bin_out;
    logic                   bin_last;
    logic [LEN_BITS-1:0]    code_len;

    modport master (
        output in_valid, in_symbol, in_k, bin_ready,
        input  in_ready, bin_valid, bin_out, bin_last, code_len
    );

    modport slave (
        input  in_valid, in_symbol, in_k, bin_ready,
        output in_ready, bin_valid, bin_out, bin_last, code_len
    );
endinterface

// File: rtl/egk_sign_map.sv
// Combinational signed-to-unsigned map: v>0 -> 2v-1, v<=0 -> -2v, one bit wider than input.
module egk_sign_map #(
    parameter int SYMBOL_BITS = 16
) (
    input  logic [SYMBOL_BITS-1:0] sym_i,
    output logic [SYMBOL_BITS:0]   map_o
);
    logic [SYMBOL_BITS:0] twice;
    logic                 positive;

    always_comb begin
        // Modular arithmetic is exact here: every result fits in SYMBOL_BITS+1 bits.
        twice    = {sym_i, 1'b0};
        positive = !sym_i[SYMBOL_BITS-1] && (|sym_i);
        map_o    = positive ? (twice - {{SYMBOL_BITS{1'b0}}, 1'b1})
                            : ({(SYMBOL_BITS+1){1'b0}} - twice);
    end
endmodule

// File: rtl/egk_stream_binarizer.sv
// EGk binarizer: one bin per cycle from the cycle after acceptance, held while bin_ready is low.
// HEVC_EGK_SIGNED_MAP_EN selects two's complement symbols mapped to unsigned at acceptance.
module egk_stream_binarizer
    import egk_pkg::*;
#(
    parameter int SYMBOL_BITS = 16,
    parameter int K_BITS      = 4,
    parameter int LEN_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    egk_stream_binarizer_if.slave  bus
);
    localparam int REM_W = rem_width(SYMBOL_BITS);
    localparam int KC_W  = kc_width(SYMBOL_BITS, K_BITS);

    localparam logic [REM_W-1:0]    REM_ONE = {{(REM_W-1){1'b0}}, 1'b1};
    localparam logic [KC_W-1:0]     KC_ONE  = {{(KC_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_BITS-1:0] LEN_ONE = {{(LEN_BITS-1){1'b0}}, 1'b1};

    if (max_code_len(SYMBOL_BITS, K_BITS) > (2 ** LEN_BITS) - 1) begin : g_len_check
        $error("LEN_BITS too small for the longest codeword");
    end

    egk_state_e          state_q, state_d;
    logic [REM_W-1:0]    rem_q, rem_d, rem_in;
    logic [KC_W-1:0]     kc_q, kc_d, kc_m1;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [REM_W-1:0]    pow_kc, sfx_shr;
    logic                pfx_one;

`ifdef HEVC_EGK_SIGNED_MAP_EN
    egk_sign_map #(.SYMBOL_BITS(SYMBOL_BITS)) u_sign_map (
        .sym_i (bus.in_symbol),
        .map_o (rem_in)
    );
`else
    assign rem_in = {1'b0, bus.in_symbol};
`endif

    // Shifts past the residual width yield zero, so large kc is handled for free.
    assign pfx_one = |(rem_q >> kc_q);
    assign pow_kc  = REM_ONE << kc_q;
    assign kc_m1   = kc_q - KC_ONE;
    assign sfx_shr = rem_q >> kc_m1;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        kc_d          = kc_q;
        len_d         = len_q;
        bus.in_ready  = 1'b0;
        bus.bin_valid = 1'b0;
        bus.bin_out   = 1'b0;
        bus.bin_last  = 1'b0;
        bus.code_len  = '0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    rem_d   = rem_in;
                    kc_d    = {{(KC_W-K_BITS){1'b0}}, bus.in_k};
                    len_d   = '0;
                    state_d = PREFIX;
                end
            end
            PREFIX: begin
                bus.bin_valid = 1'b1;
                bus.bin_out   = pfx_one;
                bus.bin_last  = !pfx_one && (kc_q == '0);
                if (bus.bin_ready) begin
                    len_d = len_q + LEN_ONE;
                    if (pfx_one) begin
                        rem_d = rem_q - pow_kc;
                        kc_d  = kc_q + KC_ONE;
                    end else begin
                        state_d = (kc_q == '0) ? IDLE : SUFFIX;
                    end
                end
            end
            SUFFIX: begin
                bus.bin_valid = 1'b1;
                bus.bin_out   = sfx_shr[0];
                bus.bin_last  = (kc_q == KC_ONE);
                if (bus.bin_ready) begin
                    kc_d  = kc_m1;
                    len_d = len_q + LEN_ONE;
                    if (kc_q == KC_ONE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.bin_last) bus.code_len = len_q + LEN_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            kc_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            kc_q    <= kc_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_egk_stream_binarizer.sv
// Bench for egk_stream_binarizer: directed and random symbols against an arithmetic EGk model.
module tb_egk_stream_binarizer;
    localparam int SB = 16;
    localparam int KB = 4;
    localparam int LB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    egk_stream_binarizer_if #(.SYMBOL_BITS(SB), .K_BITS(KB), .LEN_BITS(LB)) bus ();

    egk_stream_binarizer #(.SYMBOL_BITS(SB), .K_BITS(KB), .LEN_BITS(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp = 0;
    int nerr = 0;
    bit exp_q[$];
    bit pat[4];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // EGk via offset value: N' = N + 2^k, nb = floor(log2 N'), q = nb - k;
    // code = q ones, a zero, then the low nb bits of N'.
    function automatic void build_code(int k, logic [SB-1:0] sym);
        longint n, n1;
        int nb;
`ifdef HEVC_EGK_SIGNED_MAP_EN
        n = longint'($signed(sym));
        n = (n > 0) ? (2 * n - 1) : (-2 * n);
`else
        n = longint'(sym);
`endif
        n1 = n + (longint'(1) << k);
        nb = 0;
        while ((n1 >> (nb + 1)) != 0) nb++;
        exp_q.delete();
        for (int i = 0; i < nb - k; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = nb - 1; i >= 0; i--) exp_q.push_back(n1[i]);
    endfunction

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
    task automatic run_sym(string tag, int k, logic [SB-1:0] sym, int mode, int exp_len);
        int   idx, cyc, nbins;
        logic rdy, pv_stall, pv_out, pv_last;
        logic [LB-1:0] pv_len;

        build_code(k, sym);
        nbins = exp_q.size();

        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, " in_ready_idle"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_k      = k[KB-1:0];
        bus.in_symbol = sym;
        bus.bin_ready = 1'b0;
        tick();
        bus.in_valid  = 1'b0;
        chk({tag, " first_bin_valid"}, bus.bin_valid, 1);

        idx = 0; cyc = 0; pv_stall = 1'b0; pv_out = 1'b0; pv_last = 1'b0; pv_len = '0;
        while (idx < nbins && cyc < 400) begin
            chk({tag, " busy_in_ready"}, bus.in_ready, 0);
            chk({tag, " bin_valid"}, bus.bin_valid, 1);
            if (pv_stall) begin
                chk({tag, " stall_bin_out"}, bus.bin_out, pv_out);
                chk({tag, " stall_bin_last"}, bus.bin_last, pv_last);
                chk({tag, " stall_code_len"}, bus.code_len, pv_len);
            end
            chk({tag, " bin_out"}, bus.bin_out, exp_q[idx]);
            chk({tag, " bin_last"}, bus.bin_last, (idx == nbins - 1));
            if (idx == nbins - 1) begin
                chk({tag, " code_len"}, bus.code_len, nbins);
                if (exp_len >= 0) chk({tag, " code_len_lit"}, bus.code_len, exp_len);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = pat[cyc % 4];
            endcase
            bus.bin_ready = rdy;
            // Offers while busy must be ignored; keep quiet on the final bin.
            bus.in_valid  = (idx != nbins - 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            bus.in_symbol = SB'($urandom);
            pv_stall = !rdy; pv_out = bus.bin_out; pv_last = bus.bin_last; pv_len = bus.code_len;
            tick();
            cyc++;
            if (rdy) idx++;
        end
        chk({tag, " bins_done"}, idx, nbins);
        bus.in_valid  = 1'b0;
        bus.bin_ready = 1'b0;
        chk({tag, " done_bin_valid"}, bus.bin_valid, 0);
        chk({tag, " done_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SB-1:0] s;
        int k;

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_symbol = '0; bus.in_k = '0; bus.bin_ready = 1'b0;
        tick();
        tick();
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset bin_valid", bus.bin_valid, 0);
        chk("reset bin_out", bus.bin_out, 0);
        chk("reset bin_last", bus.bin_last, 0);
        chk("reset code_len", bus.code_len, 0);
        rst = 1'b0;
        tick();

        run_sym("k1_s0", 1, 16'h0000, 0, 2);
        run_sym("k1_s3", 1, 16'h0003, 0, 4);
`ifdef HEVC_EGK_SIGNED_MAP_EN
        run_sym("k1_sneg3", 1, 16'hFFFD, 0, 6);
        run_sym("k0_sneg1", 0, 16'hFFFF, 0, 3);
        run_sym("k0_smin", 0, 16'h8000, 0, 33);
`else
        run_sym("k0_s5", 0, 16'h0005, 0, 5);
        run_sym("k0_sffff", 0, 16'hFFFF, 0, 33);
`endif
        run_sym("bp_k1_s3", 1, 16'h0003, 2, 4);
        run_sym("k15_sffff", 15, 16'hFFFF, 1, -1);

        // Abort mid-suffix: K=1 sym=3 gives bins 1,0 then suffix.
        bus.in_valid = 1'b1; bus.in_k = 4'd1; bus.in_symbol = 16'h0003; bus.bin_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("rst pre bin_valid", bus.bin_valid, 1);
        chk("rst pre bin_out", bus.bin_out, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst bin_valid", bus.bin_valid, 0);
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst bin_out", bus.bin_out, 0);
        chk("rst bin_last", bus.bin_last, 0);
        chk("rst code_len", bus.code_len, 0);
        tick();
        chk("rst quiet bin_valid", bus.bin_valid, 0);
        bus.bin_ready = 1'b0;
        run_sym("post_rst_k0_s0", 0, 16'h0000, 0, 1);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 15);
            s = SB'($urandom);
            if (i % 3 == 0) s = s >> $urandom_range(0, 15);
            run_sym("rand", k, s, $urandom_range(0, 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
